fp_divide_iterative: RTL
========================

# fp_divide_iterative

Single-precision IEEE-754 divider (out = in1 / in2), companion to the pipelined FP multiplier in the FP ALU. It uses restoring division and produces one quotient bit per clock. It holds one operation at a time behind a valid/ready input handshake and emits a one-cycle result strobe. Flag semantics, rounding-mode encoding and the denormal flush-to-zero policy match the multiplier.

## Interface
- No parameters. Format fixed at binary32; rounding modes use the `fp_pkg` encodings RNE, RTZ, RDN, RUP, RMM.
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- valid_data_in  input  1  operands present; accepted when high with ready
- ready  output  1  block idle, can accept an operation
- in1, in2  input  32  dividend, divisor (binary32)
- rounding_mode  input  3  latched at accept
- out  output  32  result; held until the next result
- valid_data_out  output  1  one-cycle strobe, out/flags valid
- overflow, underflow, inexact, invalid_operation, divide_by_zero  output  1 each  exception flags; held with out

## Operation
- Reset values: all outputs 0 except ready=1; state=IDLE.
- States:
  - IDLE (ready=1): on accept, latch operands and rounding_mode, then classify.
    - Special case: go to DONE.
    - Otherwise: go to DIVIDE with iteration counter=0.
  - DIVIDE: 27 cycles, then ROUND.
  - ROUND: 1 cycle, then DONE.
  - DONE: drives valid_data_out=1 for one cycle, updates out/flags, returns to IDLE.
- Denormal inputs are flushed to signed zero before classification. No flag is raised for the flush.
- Special-case priority, first match wins:
  - qNaN in1 → in1.
  - qNaN in2 → in2.
  - sNaN in1 → in1 | 0x00400000, invalid.
  - sNaN in2 → in2 | 0x00400000, invalid.
  - 0/0 or inf/inf → 0x7FC00000, invalid.
  - inf/finite → signed inf.
  - finite-nonzero/0 → signed inf, divide_by_zero.
  - finite/inf or 0/finite → signed zero.
  - Sign of these results = sign1 ^ sign2.
- Datapath:
  - A = {1,m1}, B = {1,m2} (24b).
  - Remainder R is 25b, initialised to A.
  - Each DIVIDE cycle: if R ≥ B then q bit = 1 and R = R − B; then R <<= 1. Quotient bits shift into q[26:0], MSB first.
- Normalize, in the signed 10-bit exponent domain:
  - If q[26]=1: mant=q[25:3], G=q[2], Rd=q[1], S=q[0]|(R≠0), exp=e1−e2+127.
  - Else: mant=q[24:2], G=q[1], Rd=q[0], S=(R≠0), exp=e1−e2+126.
- Round-up rule by mode:
  - RNE: G&(Rd|S|mant[0]).
  - RTZ: 0.
  - RDN: sign&(G|Rd|S).
  - RUP: ~sign&(G|Rd|S).
  - RMM: G.
  - Undefined mode codes behave as RTZ.
  - Mantissa carry-out gives mant=0 and exp+1.
  - inexact = G|Rd|S.
- Overflow (exp ≥ 255 after rounding): overflow=1, inexact=1. Result:
  - RNE/RMM: inf.
  - RTZ: ±0x7F7FFFFF.
  - RDN: −inf if negative, else +max.
  - RUP: +inf if positive, else −max.
- Underflow (exp ≤ 0 after rounding): result is signed zero, underflow=1, inexact=1.

## Timing
- Accept at edge T (valid_data_in & ready). ready falls after T and rises in the cycle after the valid_data_out strobe.
- Special case: valid_data_out high in cycle T+1. Normal case: T+29 (27 DIVIDE + ROUND + DONE).
- valid_data_in while ready=0 is ignored. The operand bus need not be held after accept.
- Back-to-back operation: a new operation may be accepted on the edge where ready is high. Throughput is one operation per 30 cycles (normal) or 2 cycles (special).
- Flags are replaced on each strobe; they are not sticky across operations.
- rst_n low at any time: immediate return to IDLE, in-flight result discarded, outputs at reset values. No strobe for the aborted operation.

## Test plan
- 6.0/2.0 (0x40C00000/0x40000000), RNE → out 0x40400000 at T+29, all flags 0, valid_data_out high exactly one cycle.
- 1.0/3.0 (0x3F800000/0x40400000):
  - RNE → 0x3EAAAAAB, inexact=1.
  - RTZ → 0x3EAAAAAA, inexact=1.
  - RUP with −1.0 → 0xBEAAAAAA.
- Specials, each strobing at T+1:
  - 0x3F800000/0x00000000 → 0x7F800000, divide_by_zero=1.
  - 0/0 → 0x7FC00000, invalid=1.
  - 0x7F800001/any → 0x7FC00001, invalid=1.
- Range limits:
  - 0x7F7FFFFF/0x3F000000, RNE → 0x7F800000, overflow=1, inexact=1.
  - Same operands, RTZ → 0x7F7FFFFF.
  - 0x00800000/0x40000000 → 0x00000000, underflow=1, inexact=1.
- Handshake: hold valid_data_in high continuously with changing operands → only operands present on ready-high edges are accepted, and one strobe is produced per accept.
- Reset abort: assert rst_n low at T+10 of a normal operation → all outputs 0, ready=1, no strobe. The next operation accepted after reset completes correctly at +29.

Source files
------------

// File: rtl/fp_divide_iterative.sv
// fp_divide_iterative: single-precision IEEE-754 divider, out = in1 / in2.
// Restoring division, one quotient bit per clock, one operation in flight.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   valid_data_in      operands present; accepted when ready is also high
//   ready              idle, an operation can be accepted
//   in1, in2           dividend, divisor (binary32)
//   rounding_mode      fp_pkg encoding, latched at accept
//   out                result, held until the next result
//   valid_data_out     one-cycle strobe marking a new out/flags
//   overflow, underflow, inexact, invalid_operation, divide_by_zero
//                      exception flags, replaced on every strobe
//
// Latency from the accepting edge: special operands 1 cycle,
// normal operands 29 cycles (27 DIVIDE + ROUND + DONE).

package fp_pkg;
  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } rnd_mode_e;
endpackage

module fp_divide_iterative
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_data_in,
  output logic        ready,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [2:0]  rounding_mode,
  output logic [31:0] out,
  output logic        valid_data_out,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact,
  output logic        invalid_operation,
  output logic        divide_by_zero
);

  typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_e;

  state_e             state_q;
  logic [4:0]         cnt_q;
  logic [24:0]        r_q;
  logic [23:0]        b_q;
  logic [26:0]        q_q;
  logic signed [9:0]  exp_q;
  logic               sign_q;
  logic [2:0]         rm_q;

  // ---------------------------------------------------------------------
  // Operand classification (denormals flushed to signed zero).
  // ---------------------------------------------------------------------
  logic [7:0]  e1, e2;
  logic [22:0] m1, m2;
  logic        sgn, zero1, zero2, inf1, inf2, qnan1, qnan2, snan1, snan2;
  logic        special;
  logic [31:0] spec_res;
  logic        spec_inv, spec_dz;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    e1       = in1[30:23];
    e2       = in2[30:23];
    m1       = (e1 == 8'd0) ? 23'd0 : in1[22:0];
    m2       = (e2 == 8'd0) ? 23'd0 : in2[22:0];
    sgn      = in1[31] ^ in2[31];
    zero1    = (e1 == 8'd0);
    zero2    = (e2 == 8'd0);
    inf1     = (e1 == 8'hFF) && (m1 == 23'd0);
    inf2     = (e2 == 8'hFF) && (m2 == 23'd0);
    qnan1    = (e1 == 8'hFF) && m1[22];
    qnan2    = (e2 == 8'hFF) && m2[22];
    snan1    = (e1 == 8'hFF) && !m1[22] && (m1 != 23'd0);
    snan2    = (e2 == 8'hFF) && !m2[22] && (m2 != 23'd0);
    special  = 1'b1;
    spec_res = 32'd0;
    spec_inv = 1'b0;
    spec_dz  = 1'b0;
    if (qnan1)                                   spec_res = in1;
    else if (qnan2)                              spec_res = in2;
    else if (snan1) begin spec_res = in1 | 32'h0040_0000; spec_inv = 1'b1; end
    else if (snan2) begin spec_res = in2 | 32'h0040_0000; spec_inv = 1'b1; end
    else if ((zero1 && zero2) || (inf1 && inf2)) begin
      spec_res = 32'h7FC0_0000;
      spec_inv = 1'b1;
    end
    else if (inf1)                               spec_res = {sgn, 8'hFF, 23'd0};
    else if (zero2) begin spec_res = {sgn, 8'hFF, 23'd0}; spec_dz = 1'b1; end
    else if (inf2 || zero1)                      spec_res = {sgn, 31'd0};
    else                                         special  = 1'b0;
  end

  // ---------------------------------------------------------------------
  // One restoring-division step.
  // ---------------------------------------------------------------------
  logic        r_ge;
  logic [24:0] r_sub, r_next;

  always_comb begin
    r_ge   = (r_q >= {1'b0, b_q});
    r_sub  = r_ge ? (r_q - {1'b0, b_q}) : r_q;
    // r_sub < B < 2^24, so the shift never loses a set bit.
    r_next = r_sub << 1;
  end

  // ---------------------------------------------------------------------
  // Normalize, round, range-check.
  // ---------------------------------------------------------------------
  logic [22:0]       mant, mant_r;
  logic              g, rd, s, rup, carry;
  logic signed [9:0] exp_n, exp_r;
  logic              ovf, unf, inx;
  logic [31:0]       rnd_res;

  always_comb begin
    if (q_q[26]) begin
      mant  = q_q[25:3];
      g     = q_q[2];
      rd    = q_q[1];
      s     = q_q[0] | (r_q != 25'd0);
      exp_n = exp_q;
    end else begin
      mant  = q_q[24:2];
      g     = q_q[1];
      rd    = q_q[0];
      s     = (r_q != 25'd0);
      exp_n = exp_q - 10'sd1;
    end
    case (rm_q)
      RNE:     rup = g & (rd | s | mant[0]);
      RDN:     rup = sign_q & (g | rd | s);
      RUP:     rup = ~sign_q & (g | rd | s);
      RMM:     rup = g;
      default: rup = 1'b0;
    endcase
    {carry, mant_r} = {1'b0, mant} + {23'd0, rup};
    exp_r = exp_n + (carry ? 10'sd1 : 10'sd0);
    inx   = g | rd | s;
    ovf   = (exp_r >= 10'sd255);
    unf   = !ovf && (exp_r <= 10'sd0);
    if (ovf) begin
      case (rm_q)
        RNE, RMM: rnd_res = {sign_q, 8'hFF, 23'd0};
        RDN:      rnd_res = sign_q ? 32'hFF80_0000 : 32'h7F7F_FFFF;
        RUP:      rnd_res = sign_q ? 32'hFF7F_FFFF : 32'h7F80_0000;
        default:  rnd_res = {sign_q, 31'h7F7F_FFFF};
      endcase
    end else if (unf) begin
      rnd_res = {sign_q, 31'd0};
    end else begin
      rnd_res = {sign_q, exp_r[7:0], mant_r};
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM with registered outputs.
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      ready             <= 1'b1;
      valid_data_out    <= 1'b0;
      out               <= 32'd0;
      overflow          <= 1'b0;
      underflow         <= 1'b0;
      inexact           <= 1'b0;
      invalid_operation <= 1'b0;
      divide_by_zero    <= 1'b0;
      cnt_q             <= 5'd0;
      r_q               <= 25'd0;
      b_q               <= 24'd0;
      q_q               <= 27'd0;
      exp_q             <= 10'sd0;
      sign_q            <= 1'b0;
      rm_q              <= 3'd0;
    end else begin
      valid_data_out <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_data_in) begin
            ready  <= 1'b0;
            rm_q   <= rounding_mode;
            sign_q <= sgn;
            b_q    <= {1'b1, m2};
            r_q    <= {2'b01, m1};
            q_q    <= 27'd0;
            cnt_q  <= 5'd0;
            exp_q  <= $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'sd127;
            if (special) begin
              state_q           <= DONE;
              valid_data_out    <= 1'b1;
              out               <= spec_res;
              overflow          <= 1'b0;
              underflow         <= 1'b0;
              inexact           <= 1'b0;
              invalid_operation <= spec_inv;
              divide_by_zero    <= spec_dz;
            end else begin
              state_q <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          r_q   <= r_next;
          q_q   <= {q_q[25:0], r_ge};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd26) state_q <= ROUND;
        end
        ROUND: begin
          state_q           <= DONE;
          valid_data_out    <= 1'b1;
          out               <= rnd_res;
          overflow          <= ovf;
          underflow         <= unf;
          inexact           <= inx | ovf | unf;
          invalid_operation <= 1'b0;
          divide_by_zero    <= 1'b0;
        end
        default: begin  // DONE
          state_q <= IDLE;
          ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule
